// File: rtl/gate_sweep_unit.sv
// gate_sweep_unit: registered WIDTH-bit logic unit with eight selectable gate
// functions, a one-entry valid/ready output register, and a built-in SWEEP
// mode. SWEEP walks every (a, b) operand pair, streams each result out, and
// accumulates the sum of all transferred results in sig.
module gate_sweep_unit #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               start,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [3*WIDTH-1:0] sig
);

    typedef enum logic [1:0] {IDLE, SWEEP, FLUSH} state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [2*WIDTH-1:0]   cnt_reg;
    logic [2:0]           sweep_op_reg;
    logic [WIDTH-1:0]     y_reg;
    logic                 out_valid_reg;
    logic                 done_reg;
    logic [3*WIDTH-1:0]   sig_reg;

    logic [WIDTH-1:0]     pass_y;
    logic [WIDTH-1:0]     sweep_y;
    logic                 slot_free;
    logic                 start_ok;
    logic                 accept;
    logic                 sweep_load;
    logic                 xfer;
    logic                 cnt_last;

    // One gate evaluated on a single bit pair.
    function automatic logic gate_bit(input logic [2:0] sel, input logic x, input logic z);
        logic r;
        r = 1'b0;
        case (sel)
            3'd0:    r = x;
            3'd1:    r = ~x;
            3'd2:    r = x & z;
            3'd3:    r = x | z;
            3'd4:    r = ~(x & z);
            3'd5:    r = ~(x | z);
            3'd6:    r = x ^ z;
            default: r = ~(x ^ z);
        endcase
        return r;
    endfunction

    // Bit-sliced gate array: one for external operands, one for the sweep counter.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign pass_y[gi]  = gate_bit(op, a[gi], b[gi]);
            assign sweep_y[gi] = gate_bit(sweep_op_reg, cnt_reg[WIDTH+gi], cnt_reg[gi]);
        end
    endgenerate

    // The output slot can take a new word if it is empty or being drained now.
    assign slot_free  = ~out_valid_reg | out_ready;
    assign xfer       = out_valid_reg & out_ready;
    // A sweep may only begin from an empty output slot so sig sees sweep words only.
    assign start_ok   = (state_reg == IDLE) & start & ~out_valid_reg;
    assign accept     = in_valid & in_ready;
    assign sweep_load = (state_reg == SWEEP) & slot_free;
    assign cnt_last   = &cnt_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok)              state_next = SWEEP;
            SWEEP:   if (sweep_load && cnt_last) state_next = FLUSH;
            FLUSH:   if (xfer)                  state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // FSM outputs; start takes priority over a word offered in the same cycle.
    always_comb begin
        busy     = (state_reg != IDLE);
        in_ready = (state_reg == IDLE) & ~start & slot_free;
    end

    // Datapath: output register, sweep counter, latched op, signature, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            sig_reg       <= '0;
            cnt_reg       <= '0;
            sweep_op_reg  <= '0;
        end else begin
            done_reg <= (state_reg == FLUSH) & xfer;

            if (accept) begin
                y_reg         <= pass_y;
                out_valid_reg <= 1'b1;
            end else if (sweep_load) begin
                y_reg         <= sweep_y;
                out_valid_reg <= 1'b1;
            end else if (xfer) begin
                out_valid_reg <= 1'b0;
            end

            if (start_ok) begin
                cnt_reg      <= '0;
                sweep_op_reg <= op;
            end else if (sweep_load) begin
                // Wraps to zero naturally after the all-ones word.
                cnt_reg <= cnt_reg + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end

            if (start_ok)
                sig_reg <= '0;
            else if (xfer && (state_reg != IDLE))
                sig_reg <= sig_reg + {{(2*WIDTH){1'b0}}, y_reg};
        end
    end

    assign y         = y_reg;
    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign sig       = sig_reg;

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Bench for gate_sweep_unit: a WIDTH=4 instance for pass mode and a WIDTH=2
// instance for exhaustive sweeps, checked against a behavioural gate model.
module tb_gate_sweep_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance signals
    logic [2:0]  op4 = '0;
    logic [3:0]  a4 = '0, b4 = '0, y4;
    logic        iv4 = 1'b0, ir4, st4 = 1'b0, ov4, ordy4 = 1'b0, busy4, done4;
    logic [11:0] sig4;

    // WIDTH=2 instance signals
    logic [2:0]  op2 = '0;
    logic [1:0]  a2 = '0, b2 = '0, y2;
    logic        iv2 = 1'b0, ir2, st2 = 1'b0, ov2, ordy2 = 1'b0, busy2, done2;
    logic [5:0]  sig2;

    gate_sweep_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .op(op4), .a(a4), .b(b4),
        .in_valid(iv4), .in_ready(ir4), .start(st4), .y(y4),
        .out_valid(ov4), .out_ready(ordy4), .busy(busy4), .done(done4), .sig(sig4)
    );

    gate_sweep_unit #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .op(op2), .a(a2), .b(b2),
        .in_valid(iv2), .in_ready(ir2), .start(st2), .y(y2),
        .out_valid(ov2), .out_ready(ordy2), .busy(busy2), .done(done2), .sig(sig2)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
    } pass_vec_t;

    pass_vec_t tbl[8];

    logic [1:0] got[$];
    logic [1:0] expw[$];
    bit         done_seen;
    int         cycles;
    logic [1:0] or_tbl[16]  = '{0,1,2,3,1,1,3,3,2,3,2,3,3,3,3,3};
    logic [1:0] xor_tbl[16] = '{0,1,2,3,1,0,3,2,2,3,0,1,3,2,1,0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gate truth as plain vector arithmetic, masked to w bits.
    function automatic logic [7:0] ref_gate(input logic [2:0] o, input logic [7:0] x,
                                            input logic [7:0] z, input int w);
        logic [7:0] r;
        case (o)
            3'd0:    r = x;
            3'd1:    r = ~x;
            3'd2:    r = x & z;
            3'd3:    r = x | z;
            3'd4:    r = ~(x & z);
            3'd5:    r = ~(x | z);
            3'd6:    r = x ^ z;
            default: r = ~(x ^ z);
        endcase
        return r & 8'((1 << w) - 1);
    endfunction

    // Expected word stream of a WIDTH=2 sweep: a is the high half, b the low half.
    task automatic build_expected(input logic [2:0] sop, output int total);
        logic [7:0] r;
        expw.delete();
        total = 0;
        for (int ai = 0; ai < 4; ai++)
            for (int bi = 0; bi < 4; bi++) begin
                r = ref_gate(sop, 8'(ai), 8'(bi), 2);
                expw.push_back(r[1:0]);
                total += int'(r);
            end
    endtask

    // Run a WIDTH=2 sweep, logging transferred words into got. Stops early once
    // abort_after words have transferred (abort_after < 0 runs to completion).
    task automatic run_sweep(input logic [2:0] sop, input bit rand_ready,
                             input bit poke, input int abort_after);
        got.delete();
        done_seen = 0;
        cycles = 0;
        op2 = sop; st2 = 1'b1; iv2 = 1'b0; ordy2 = 1'b1;
        tick();
        st2 = 1'b0;
        check("sweep_busy_after_start", busy2, 1);
        check("sweep_sig_cleared", sig2, 0);
        for (int c = 0; c < 400; c++) begin
            if (done_seen) break;
            if (abort_after >= 0 && got.size() >= abort_after) break;
            ordy2 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                st2 = ($urandom_range(0, 3) == 0);
                op2 = 3'($urandom_range(0, 7));
                a2  = 2'($urandom_range(0, 3));
                b2  = 2'($urandom_range(0, 3));
                iv2 = 1'($urandom_range(0, 1));
            end
            if (ov2 && ordy2) got.push_back(y2);
            tick();
            cycles++;
            if (done2) begin
                done_seen = 1;
                check("done_with_last_word", got.size(), 16);
                check("busy_low_at_done", busy2, 0);
            end
        end
        st2 = 1'b0; iv2 = 1'b0; op2 = sop;
    endtask

    // Full sweep check against the model, optionally against a literal table.
    task automatic sweep_and_check(input logic [2:0] sop, input bit rand_ready, input bit poke,
                                   input int tbl_sel, input int exp_sig_lit);
        int total;
        logic [1:0] tw;
        build_expected(sop, total);
        run_sweep(sop, rand_ready, poke, -1);
        check("sweep_done_seen", done_seen, 1);
        check("sweep_word_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            check($sformatf("sweep_op%0d_word%0d", sop, i), got[i], expw[i]);
            if (tbl_sel != 0) begin
                tw = (tbl_sel == 1) ? or_tbl[i] : xor_tbl[i];
                check($sformatf("sweep_table_word%0d", i), got[i], tw);
            end
        end
        check("sweep_sig_model", sig2, total);
        if (exp_sig_lit >= 0) check("sweep_sig_literal", sig2, exp_sig_lit);
        if (!rand_ready) check("sweep_done_edge", cycles, 17);
        $display("[TB] sweep op=%0d words=%0d sig=%0d cycles=%0d", sop, got.size(), sig2, cycles);
        tick();
        check("done_one_cycle", done2, 0);
        check("busy_low_after", busy2, 0);
        check("sig_holds", sig2, total);
    endtask

    initial begin
        logic       exp_v;
        logic [3:0] exp_y;
        logic       exp_ir;
        logic [7:0] r;

        tbl[0] = '{op: 3'd4, a: 4'hC, b: 4'hA, y: 4'h7};
        tbl[1] = '{op: 3'd7, a: 4'h5, b: 4'h3, y: 4'h9};
        tbl[2] = '{op: 3'd0, a: 4'h3, b: 4'hF, y: 4'h3};
        tbl[3] = '{op: 3'd1, a: 4'h3, b: 4'h0, y: 4'hC};
        tbl[4] = '{op: 3'd2, a: 4'hC, b: 4'hA, y: 4'h8};
        tbl[5] = '{op: 3'd3, a: 4'hC, b: 4'hA, y: 4'hE};
        tbl[6] = '{op: 3'd5, a: 4'hC, b: 4'hA, y: 4'h1};
        tbl[7] = '{op: 3'd6, a: 4'hC, b: 4'hA, y: 4'h6};

        // ---- Reset ----
        tick(); tick();
        rst_n = 1'b1;
        op4 = 3'd2; a4 = 4'hF; b4 = 4'hF; iv4 = 1'b1; ordy4 = 1'b0;
        tick();
        check("preload_valid", ov4, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_y", y4, 0);
        check("rst_out_valid", ov4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_sig", sig4, 0);
        iv4 = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset4", ir4, 1);
        check("in_ready_after_reset2", ir2, 1);

        // ---- Pass mode table ----
        for (int i = 0; i < 8; i++) begin
            op4 = tbl[i].op; a4 = tbl[i].a; b4 = tbl[i].b; iv4 = 1'b1; ordy4 = 1'b1;
            check("pass_in_ready", ir4, 1);
            tick();
            check($sformatf("pass_y_vec%0d", i), y4, tbl[i].y);
            check($sformatf("pass_valid_vec%0d", i), ov4, 1);
            $display("[TB] pass op=%0d a=%h b=%h y=%h", tbl[i].op, tbl[i].a, tbl[i].b, y4);
        end
        iv4 = 1'b0;
        tick();
        check("pass_drained", ov4, 0);

        // ---- Backpressure ----
        op4 = 3'd4; a4 = 4'hC; b4 = 4'hA; iv4 = 1'b1; ordy4 = 1'b0;
        tick();
        check("bp_first_y", y4, 4'h7);
        a4 = 4'h3; b4 = 4'h3;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", ir4, 0);
            tick();
            check("bp_y_stable", y4, 4'h7);
            check("bp_valid_held", ov4, 1);
        end
        ordy4 = 1'b1;
        #1;
        check("bp_in_ready_on_release", ir4, 1);
        iv4 = 1'b0;
        tick();
        check("bp_transferred", ov4, 0);
        $display("[TB] backpressure y=%h released", 4'h7);

        // ---- Randomised pass mode against a one-entry slot model ----
        exp_v = 1'b0; exp_y = '0;
        for (int i = 0; i < 80; i++) begin
            op4 = 3'($urandom_range(0, 7));
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            iv4 = 1'($urandom_range(0, 1));
            ordy4 = 1'($urandom_range(0, 1));
            exp_ir = ~exp_v | ordy4;
            #1;
            check("rand_in_ready", ir4, exp_ir);
            if (iv4 && exp_ir) begin
                r = ref_gate(op4, 8'(a4), 8'(b4), 4);
                exp_y = r[3:0];
                exp_v = 1'b1;
            end else if (exp_v && ordy4) begin
                exp_v = 1'b0;
            end
            tick();
            check("rand_valid", ov4, exp_v);
            if (exp_v) check("rand_y", y4, exp_y);
        end
        iv4 = 1'b0; ordy4 = 1'b1;
        tick();
        $display("[TB] random pass phase complete");

        // ---- Sweeps on the WIDTH=2 instance ----
        sweep_and_check(3'd3, 1'b0, 1'b0, 1, 36);
        sweep_and_check(3'd6, 1'b1, 1'b1, 2, 24);

        // ---- Abort mid-sweep with reset ----
        run_sweep(3'd2, 1'b0, 1'b0, 5);
        check("abort_words_before_reset", got.size(), 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_y", y2, 0);
        check("abort_out_valid", ov2, 0);
        check("abort_busy", busy2, 0);
        check("abort_done", done2, 0);
        check("abort_sig", sig2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", done2, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_idle_no_done", done2, 0);
            check("abort_idle_busy", busy2, 0);
        end
        $display("[TB] abort after 5 transfers, outputs cleared");
        sweep_and_check(3'd2, 1'b0, 1'b0, 0, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
